// File: rtl/aes_ahb_pkg.sv
// Shared register map, bit positions and bus-FSM states for the AES AHB-Lite slave.
package aes_ahb_pkg;
  // Register offsets as word indices, HADDR[3:2].
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIN    = 2'd2;
  localparam logic [1:0] REG_DOUT   = 2'd3;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_TYPE   = 1;
  localparam int unsigned CTRL_ENCDEC = 2;

  localparam int unsigned STAT_KEY_DONE  = 0;
  localparam int unsigned STAT_IN_FULL   = 1;
  localparam int unsigned STAT_OUT_VALID = 2;
  localparam int unsigned STAT_OVERRUN   = 3;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_XFER  = 3'd1,
    S_STALL = 3'd2,
    S_ERR1  = 3'd3,
    S_ERR2  = 3'd4
  } ahb_state_t;
endpackage

// File: rtl/aes_word_buf.sv
// 4x32 block buffer: word-serial push or parallel load, count-tracked pop/clear.
module aes_word_buf #(
  parameter int unsigned WORDS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [31:0]  push_data_i,
  input  logic         load_i,
  input  logic [127:0] load_data_i,
  input  logic         pop_i,
  input  logic         clear_i,
  output logic [2:0]   count_o,
  output logic [127:0] block_o
);
  localparam logic [2:0] FULL_CNT = 3'(WORDS);

  logic [2:0]   count_q, count_d;
  logic [127:0] block_q, block_d;

  always_comb begin
    count_d = count_q;
    block_d = block_q;
    if (load_i) begin
      block_d = load_data_i;
      count_d = FULL_CNT;
    end else if (clear_i) begin
      count_d = '0;
    end else if (push_i && count_q != FULL_CNT) begin
      // Word n lives at bit (3-n)*32; for 2-bit n that base is ~n*32.
      block_d[{~count_q[1:0], 5'd0} +: 32] = push_data_i;
      count_d = count_q + 3'd1;
    end else if (pop_i && count_q != '0) begin
      count_d = count_q - 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      block_q <= '0;
    end else begin
      count_q <= count_d;
      block_q <= block_d;
    end
  end

  assign count_o = count_q;
  assign block_o = block_q;
endmodule

// File: rtl/ahb_slave_aes.sv
// AHB-Lite register front end of the AES accelerator: CTRL/STATUS decode and
// 32-bit <-> 128-bit block buffering toward the AES controller.
module ahb_slave_aes
  import aes_ahb_pkg::*;
#(
  parameter int unsigned BLOCK_WORDS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         HSEL,
  input  logic [3:0]   HADDR,
  input  logic [1:0]   HTRANS,
  input  logic         HWRITE,
  input  logic [2:0]   HSIZE,
  input  logic [31:0]  HWDATA,
  input  logic         HREADY,
  output logic [31:0]  HRDATA,
  output logic         HREADYOUT,
  output logic         HRESP,
  output logic         start,
  output logic         data_type,
  output logic         enc_dec,
  output logic         data_received,
  output logic [127:0] rx_block,
  input  logic         ahb_mode,
  input  logic         ahb_shift_en,
  input  logic         done_chg_key,
  input  logic [127:0] tx_block
);
  localparam logic [2:0] FULL_CNT = 3'(BLOCK_WORDS);

  ahb_state_t  state_q, state_d;
  logic [1:0]  addr_q, addr_d;
  logic        wr_q, wr_d;
  logic        start_q, start_d, data_type_q, data_type_d, enc_dec_q, enc_dec_d;
  logic        key_done_q, key_done_d, overrun_q, overrun_d;

  logic [2:0]   in_cnt, out_cnt;
  logic [127:0] in_block, out_block;
  logic         in_full, out_valid, consume, load, in_full_nx, out_valid_nx;
  logic         xfer, ctrl_wr, din_push, status_rd, dout_pop, sample, illegal;
  logic [3:0]   status;
  logic [31:0]  out_word;
  logic         unused_htrans0;

  assign unused_htrans0 = HTRANS[0];

  assign in_full   = (in_cnt == FULL_CNT);
  assign out_valid = (out_cnt != '0);
  assign consume   = ahb_shift_en & ~ahb_mode & in_full;
  assign load      = ahb_shift_en & ahb_mode;

  assign xfer      = (state_q == S_XFER);
  assign ctrl_wr   = xfer & wr_q & (addr_q == REG_CTRL);
  assign din_push  = xfer & wr_q & (addr_q == REG_DIN);
  assign status_rd = xfer & ~wr_q & (addr_q == REG_STATUS);
  assign dout_pop  = xfer & ~wr_q & (addr_q == REG_DOUT);

  // Decisions for a new address phase must see buffer state after this edge.
  assign in_full_nx   = ~consume & (in_full | (din_push & (in_cnt == FULL_CNT - 3'd1)));
  assign out_valid_nx = load | (out_valid & ~(dout_pop & (out_cnt == 3'd1)));

  assign sample  = HSEL & HTRANS[1] & HREADY;
  assign illegal = (HSIZE != HSIZE_WORD) || (HADDR[1:0] != 2'b00)
                || (HWRITE && (HADDR[3:2] == REG_STATUS || HADDR[3:2] == REG_DOUT))
                || (!HWRITE && HADDR[3:2] == REG_DOUT && !out_valid_nx);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    case (state_q)
      S_STALL: if (consume) state_d = S_XFER;
      S_ERR1:  state_d = S_ERR2;
      default: begin
        if (HREADY) begin
          if (sample) begin
            addr_d = HADDR[3:2];
            wr_d   = HWRITE;
            if (illegal)
              state_d = S_ERR1;
            else if (HWRITE && HADDR[3:2] == REG_DIN && in_full_nx)
              state_d = S_STALL;
            else
              state_d = S_XFER;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
    endcase
  end

  assign start_d     = ctrl_wr & HWDATA[CTRL_START];
  assign data_type_d = ctrl_wr ? HWDATA[CTRL_TYPE]   : data_type_q;
  assign enc_dec_d   = ctrl_wr ? HWDATA[CTRL_ENCDEC] : enc_dec_q;
  // Sticky sets take priority over clear-on-read.
  assign key_done_d  = done_chg_key | (key_done_q & ~status_rd);
  assign overrun_d   = (load & out_valid) | (overrun_q & ~status_rd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      start_q     <= 1'b0;
      data_type_q <= 1'b0;
      enc_dec_q   <= 1'b0;
      key_done_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      start_q     <= start_d;
      data_type_q <= data_type_d;
      enc_dec_q   <= enc_dec_d;
      key_done_q  <= key_done_d;
      overrun_q   <= overrun_d;
    end
  end

  aes_word_buf #(.WORDS(BLOCK_WORDS)) u_in_buf (
    .clk(clk), .rst(rst),
    .push_i(din_push), .push_data_i(HWDATA),
    .load_i(1'b0), .load_data_i('0),
    .pop_i(1'b0), .clear_i(consume),
    .count_o(in_cnt), .block_o(in_block)
  );

  aes_word_buf #(.WORDS(BLOCK_WORDS)) u_out_buf (
    .clk(clk), .rst(rst),
    .push_i(1'b0), .push_data_i('0),
    .load_i(load), .load_data_i(tx_block),
    .pop_i(dout_pop), .clear_i(1'b0),
    .count_o(out_cnt), .block_o(out_block)
  );

  // Read pointer is 4-count, so the current word sits at bit (count-1)*32.
  assign out_word = out_block[{out_cnt[1:0] - 2'd1, 5'd0} +: 32];

  always_comb begin
    status = '0;
    status[STAT_KEY_DONE]  = key_done_q;
    status[STAT_IN_FULL]   = in_full;
    status[STAT_OUT_VALID] = out_valid;
    status[STAT_OVERRUN]   = overrun_q;
  end

  always_comb begin
    HRDATA = '0;
    if (xfer && !wr_q) begin
      case (addr_q)
        REG_CTRL: begin
          HRDATA[CTRL_TYPE]   = data_type_q;
          HRDATA[CTRL_ENCDEC] = enc_dec_q;
        end
        REG_STATUS: HRDATA[3:0] = status;
        REG_DOUT:   HRDATA = out_word;
        default:    HRDATA = '0;
      endcase
    end
  end

  assign HREADYOUT     = ~(state_q == S_STALL || state_q == S_ERR1);
  assign HRESP         = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign start         = start_q;
  assign data_type     = data_type_q;
  assign enc_dec       = enc_dec_q;
  assign data_received = in_full;
  assign rx_block      = in_block;
endmodule
